// File: rtl/chunked_adder.sv
// chunked_adder: multi-cycle add/sub, CHUNK bits per clock,
// LSB chunk first, carry held in a register between chunks.
module chunked_adder #(
  parameter int WIDTH = 10,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] ar;
  logic [WIDTH-1:0] br;
  logic [WIDTH-1:0] work;
  logic             amsb;
  logic             bmsb;
  logic             carry;
  logic [IW-1:0]    idx;

  logic [CHUNK:0]   psum;
  logic [WIDTH-1:0] wnext;
  logic             last;
  logic             accept;

  assign ready  = (state != S_RUN);
  assign busy   = (state == S_RUN);
  assign last   = (idx == IW'(NCH - 1));
  assign accept = start && (state != S_RUN);

  // One chunk of the sum; the result is shifted in from the top so
  // that after NCH steps it sits at its final bit position.
  always_comb begin
    psum  = {1'b0, ar[CHUNK-1:0]}
          + {1'b0, br[CHUNK-1:0]}
          + {{CHUNK{1'b0}}, carry};
    wnext = (work >> CHUNK)
          | (WIDTH'(psum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // Handshake FSM, chunk datapath and result publish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ar    <= '0;
      br    <= '0;
      work  <= '0;
      amsb  <= 1'b0;
      bmsb  <= 1'b0;
      carry <= 1'b0;
      idx   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (1'b1)
        busy: begin
          ar    <= ar >> CHUNK;
          br    <= br >> CHUNK;
          work  <= wnext;
          carry <= psum[CHUNK];
          idx   <= idx + 1'b1;
          if (last) begin
            sum   <= wnext;
            cout  <= psum[CHUNK];
            ovf   <= (amsb == bmsb) &&
                     (psum[CHUNK-1] != amsb);
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        accept: begin
          ar    <= a;
          br    <= sub ? ~b : b;
          amsb  <= a[WIDTH-1];
          bmsb  <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
          carry <= sub;
          idx   <= '0;
          work  <= '0;
          state <= S_RUN;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
